// File: rtl/float8_accum_ctrl.sv
// Sequences a shared external float8 adder to reduce a burst of iLen operands to one sum.
// Latency: result valid the cycle after the last accepted operand (N+1 cycles from ACC entry).
// Backpressure: oDataReady only in ACC; result held in DONE until iResultReady, no new burst until then.
module float8_accum_ctrl #(
    parameter int LEN_W = 8
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic [LEN_W-1:0] iLen,
    input  logic [7:0]       iData,
    input  logic             iDataValid,
    output logic             oDataReady,
    output logic [7:0]       oAddA,
    output logic [7:0]       oAddB,
    input  logic [7:0]       iAddSum,
    input  logic             iAddOvf,
    output logic [7:0]       oResult,
    output logic             oResultValid,
    input  logic             iResultReady,
    output logic             oOverflow,
    output logic             oBusy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       acc;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] len;
    logic             ovf;
    logic             xfer;
    logic             last_xfer;
    logic             start_ok;

    // len is never zero while in ACC, so len-1 cannot wrap; cnt tops out at len-1 before the compare.
    assign xfer      = (state == ACC) && iDataValid;
    assign last_xfer = xfer && (cnt == (len - LEN_W'(1)));
    assign start_ok  = (state == IDLE) && iStart;

    // The adder always sees the accumulator and the incoming operand.
    assign oAddA        = acc;
    assign oAddB        = iData;
    assign oResult      = acc;
    assign oOverflow    = ovf;
    assign oDataReady   = (state == ACC);
    assign oResultValid = (state == DONE);
    assign oBusy        = (state != IDLE);

    // State register.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a start arriving in DONE is ignored because it is only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (iStart) begin
                    state_nxt = (iLen != '0) ? ACC : DONE;
                end
            end
            ACC: begin
                if (last_xfer) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (iResultReady) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Accumulator, counter and sticky overflow; saturation keeps the accumulator's own sign.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            acc <= 8'h00;
            cnt <= '0;
            len <= '0;
            ovf <= 1'b0;
        end else if (start_ok) begin
            acc <= 8'h00;
            cnt <= '0;
            len <= iLen;
            ovf <= 1'b0;
        end else if (xfer) begin
            cnt <= cnt + LEN_W'(1);
            if (iAddOvf) begin
                acc <= {acc[7], 7'h7F};
                ovf <= 1'b1;
            end else begin
                acc <= iAddSum;
            end
        end
    end

endmodule
